tiny_dnn_axil_master: RTL

//  AXI-Lite initiator that drives the tiny_dnn control-register slave
//  (16 x 32-bit regs at byte offsets idx*4, 0..14 in use).

---
 rtl/tiny_dnn_reg_pkg.sv | 38 +++
 rtl/tiny_dnn_axil_master.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tiny_dnn_reg_pkg.sv
// Shared definitions for the tiny_dnn control-register block and its AXI-Lite initiator:
// register indices, AXI response codes and the initiator state encoding.
package tiny_dnn_reg_pkg;

  localparam logic [3:0] REG_CTRL = 4'd0;
  localparam logic [3:0] REG_FS   = 4'd1;
  localparam logic [3:0] REG_KS   = 4'd2;
  localparam logic [3:0] REG_KH   = 4'd3;
  localparam logic [3:0] REG_KW   = 4'd4;
  localparam logic [3:0] REG_SS   = 4'd5;
  localparam logic [3:0] REG_IH   = 4'd6;
  localparam logic [3:0] REG_IW   = 4'd7;
  localparam logic [3:0] REG_IC   = 4'd8;
  localparam logic [3:0] REG_OC   = 4'd9;
  localparam logic [3:0] REG_SRC  = 4'd10;
  localparam logic [3:0] REG_WGT  = 4'd11;
  localparam logic [3:0] REG_DST  = 4'd12;
  localparam logic [3:0] REG_OH   = 4'd13;
  localparam logic [3:0] REG_OW   = 4'd14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RSP
  } axil_state_e;

  // Base must be 64-byte aligned so OR-ing in the word offset never carries.
  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [3:0] idx);
    return base | {26'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/tiny_dnn_axil_master.sv
// Single-outstanding AXI-Lite initiator: turns one cmd handshake into one
// single-beat write or read and returns the result on a rsp handshake.
module tiny_dnn_axil_master
  import tiny_dnn_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  axil_state_e state_q, state_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        write_q, write_d;

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      write_q   <= write_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    write_d   = write_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = reg_addr(BASE_ADDR, cmd_addr);
          write_d = cmd_write;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        // AW and W retire independently; leave only once both have handshaken.
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          err_d   = |M_AXI_BRESP;
          rdata_d = '0;
          state_d = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          err_d   = |M_AXI_RRESP;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = (state_q == ST_IDLE);
    busy          = (state_q != ST_IDLE);
    M_AXI_BREADY  = (state_q == ST_WR_RESP);
    M_AXI_RREADY  = (state_q == ST_RD_DATA);
    rsp_valid     = (state_q == ST_RSP);
    rsp_write     = write_q;
    rsp_rdata     = rdata_q;
    rsp_err       = err_q;
    M_AXI_AWADDR  = addr_q;
    M_AXI_ARADDR  = addr_q;
    M_AXI_AWVALID = awvalid_q;
    M_AXI_WVALID  = wvalid_q;
    M_AXI_ARVALID = arvalid_q;
    M_AXI_WDATA   = wdata_q;
    M_AXI_WSTRB   = 4'hF;
  end

endmodule
